// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter: one-deep holding register feeding a shift register, so frames go out back-to-back.
// A write is taken when ts=1 and starts on the next en_tx edge; a write while ts=0 is dropped.
module uart_tx_unit #(
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_tx,
    input  logic [7:0] d_in,
    input  logic       we,
    output logic       txd,
    output logic       ts,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic STOP_INIT = 1'(STOP_BITS - 1);

    state_t     state_q, state_d;
    logic [7:0] thr_q, thr_d;
    logic       thr_full_q, thr_full_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] cnt_bits_q, cnt_bits_d;
    logic       cnt_stop_q, cnt_stop_d;
    logic       txd_q, txd_d;
    logic       reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            thr_q      <= '0;
            thr_full_q <= 1'b0;
            sh_q       <= '0;
            cnt_bits_q <= '0;
            cnt_stop_q <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            thr_full_q <= thr_full_d;
            sh_q       <= sh_d;
            cnt_bits_q <= cnt_bits_d;
            cnt_stop_q <= cnt_stop_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        thr_full_d = thr_full_q;
        sh_d       = sh_q;
        cnt_bits_d = cnt_bits_q;
        cnt_stop_d = cnt_stop_q;
        txd_d      = txd_q;
        reload     = 1'b0;

        // Write needs an empty thr and reload needs a full one, so they never collide.
        if (we && !thr_full_q) begin
            thr_d      = d_in;
            thr_full_d = 1'b1;
        end

        if (en_tx) begin
            case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    if (thr_full_q) reload = 1'b1;
                end
                START: begin
                    txd_d      = sh_q[0];
                    sh_d       = sh_q >> 1;
                    cnt_bits_d = 3'd7;
                    state_d    = DATA;
                end
                DATA: begin
                    if (cnt_bits_q == 3'd0) begin
                        txd_d      = 1'b1;
                        cnt_stop_d = STOP_INIT;
                        state_d    = STOP;
                    end else begin
                        txd_d      = sh_q[0];
                        sh_d       = sh_q >> 1;
                        cnt_bits_d = cnt_bits_q - 3'd1;
                    end
                end
                STOP: begin
                    if (cnt_stop_q != 1'b0) begin
                        cnt_stop_d = 1'b0;
                        txd_d      = 1'b1;
                    end else if (thr_full_q) begin
                        reload = 1'b1;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase

            if (reload) begin
                sh_d       = thr_q;
                thr_full_d = 1'b0;
                txd_d      = 1'b0;
                state_d    = START;
            end
        end
    end

    always_comb begin
        txd  = txd_q;
        ts   = !thr_full_q;
        busy = (state_q != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit: table of single frames plus hand-written multi-frame sequences.
module tb_uart_tx_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_tx;
    logic [7:0] d_in;
    logic       we;
    logic       txd, ts, busy;
    logic       txd2, ts2, busy2;

    int tests = 0;
    int fails = 0;
    logic ts_log [0:31];

    always #5 clk = ~clk;

    uart_tx_unit #(.STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in), .we(we),
        .txd(txd), .ts(ts), .busy(busy)
    );

    uart_tx_unit #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .en_tx(en_tx), .d_in(d_in), .we(we),
        .txd(txd2), .ts(ts2), .busy(busy2)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // frame[9] is the start bit, sent first
    } vec_t;

    vec_t vecs [0:3];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic w, input logic [7:0] d);
        @(negedge clk);
        en_tx = e;
        we    = w;
        d_in  = d;
        @(posedge clk);
        #1;
    endtask

    // One bit period of four clocks; an optional write lands on the clock after the tick.
    task automatic bit_period(input logic w, input logic [7:0] d, output logic t, output logic s, output logic b);
        drive(1'b1, 1'b0, 8'h00);
        t = txd;
        s = ts;
        b = busy;
        drive(1'b0, w, d);
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic run_periods(input string nm, input int n, input logic [31:0] exp_bits,
                               input int w1_at, input logic [7:0] w1_d,
                               input int w2_at, input logic [7:0] w2_d);
        logic t, s, b, w;
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            w = (i == w1_at) || (i == w2_at);
            d = (i == w1_at) ? w1_d : w2_d;
            bit_period(w, d, t, s, b);
            ts_log[i] = s;
            check($sformatf("%s txd bit %0d", nm, i), 32'(t), 32'(exp_bits[n-1-i]));
            check($sformatf("%s busy bit %0d", nm, i), 32'(b), 32'd1);
        end
    endtask

    task automatic idle_check(input string nm);
        logic t, s, b;
        bit_period(1'b0, 8'h00, t, s, b);
        check({nm, " idle txd"}, 32'(t), 32'd1);
        check({nm, " idle busy"}, 32'(b), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic t, s, b;

        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h3C, 10'b0001111001};
        vecs[2] = '{8'h80, 10'b0000000011};
        vecs[3] = '{8'h01, 10'b0100000001};

        rst = 1'b1; en_tx = 1'b0; we = 1'b0; d_in = 8'h00;
        #12;
        check("reset txd", 32'(txd), 32'd1);
        check("reset ts", 32'(ts), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset txd2", 32'(txd2), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Single frames from the table
        for (int v = 0; v < 4; v++) begin
            drive(1'b0, 1'b1, vecs[v].data);
            check($sformatf("vec%0d ts after write", v), 32'(ts), 32'd0);
            check($sformatf("vec%0d busy before tick", v), 32'(busy), 32'd0);
            run_periods($sformatf("vec%0d", v), 10, 32'(vecs[v].frame), -1, 8'h00, -1, 8'h00);
            check($sformatf("vec%0d ts after reload", v), 32'(ts_log[0]), 32'd1);
            idle_check($sformatf("vec%0d", v));
        end

        // Back-to-back 0x55 then 0x0F, second written right after ts returns high
        drive(1'b0, 1'b1, 8'h55);
        run_periods("b2b", 20, {12'h0, 10'b0101010101, 10'b0111100001}, 0, 8'h0F, -1, 8'h00);
        check("b2b ts p0", 32'(ts_log[0]), 32'd1);
        check("b2b ts p5", 32'(ts_log[5]), 32'd0);
        check("b2b ts p10", 32'(ts_log[10]), 32'd1);
        idle_check("b2b");

        // 0x01, 0x02 accepted, 0x03 dropped
        drive(1'b0, 1'b1, 8'h01);
        run_periods("drop", 20, {12'h0, 10'b0100000001, 10'b0010000001}, 0, 8'h02, 1, 8'h03);
        for (int i = 1; i < 10; i++)
            check($sformatf("drop ts p%0d", i), 32'(ts_log[i]), 32'd0);
        check("drop ts p10", 32'(ts_log[10]), 32'd1);
        idle_check("drop a");
        idle_check("drop b");

        // Two stop bits on the second instance
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        drive(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 11; i++) begin
            bit_period(1'b0, 8'h00, t, s, b);
            check($sformatf("stop2 txd bit %0d", i), 32'(txd2), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("stop2 busy bit %0d", i), 32'(busy2), 32'd1);
        end
        bit_period(1'b0, 8'h00, t, s, b);
        check("stop2 idle busy", 32'(busy2), 32'd0);
        check("stop2 idle txd", 32'(txd2), 32'd1);
        idle_check("stop2 dut1");

        // Asynchronous reset during data bit 4 of 0x00
        drive(1'b0, 1'b1, 8'h00);
        run_periods("rst", 6, 32'd0, -1, 8'h00, -1, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst txd", 32'(txd), 32'd1);
        check("rst ts", 32'(ts), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h80);
        run_periods("post rst", 10, 32'(10'b0000000011), -1, 8'h00, -1, 8'h00);
        idle_check("post rst");

        // Continuous en_tx: write coincides with a tick, then one bit per clock
        drive(1'b1, 1'b1, 8'h3C);
        check("cont ts", 32'(ts), 32'd0);
        check("cont txd idle", 32'(txd), 32'd1);
        check("cont busy idle", 32'(busy), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            logic [19:0] exp_c;
            exp_c = {10'b0001111001, 10'b0100010001};
            drive(1'b1, (i == 2) || (i == 3), (i == 2) ? 8'h11 : 8'h22);
            check($sformatf("cont txd %0d", i), 32'(txd), 32'(exp_c[20-i]));
            check($sformatf("cont busy %0d", i), 32'(busy), 32'd1);
            if (i == 3) check("cont ts full", 32'(ts), 32'd0);
        end
        drive(1'b1, 1'b0, 8'h00);
        check("cont end txd", 32'(txd), 32'd1);
        check("cont end busy", 32'(busy), 32'd0);
        drive(1'b1, 1'b0, 8'h00);
        check("cont no third", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_unit.md
# uart_tx_unit

Transmitting half of the MiniUart. It accepts 8-bit words from the CPU bus into a one-deep holding register and serializes them on TxD as 8N1 frames: start bit, 8 data bits LSB first, then 1 or 2 stop bits. Bit timing comes from a one-cycle baud-tick enable generated by the UART divider. A holding register plus a shift register gives double buffering, so consecutive writes go out back-to-back with no idle gap between frames.

## Interface
Parameters:
- STOP_BITS, default 1: number of stop bits per frame; legal values are 1 and 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- en_tx  input  1  baud tick; one clk-cycle pulse per bit time; all FSM and TxD updates happen only on clk edges where en_tx=1
- d_in  input  8  write data from CPU
- we  input  1  write strobe; sampled on posedge clk
- txd  output  1  serial output; registered; idle level 1
- ts  output  1  transmit status; 1 = holding register empty, so a write is accepted
- busy  output  1  1 while a frame is on the line (FSM not IDLE)

## Operation
- Holding register thr[7:0] with flag thr_full; ts = !thr_full.
- Write rule: on a clk edge with we=1 and ts=1, thr <= d_in and thr_full <= 1. A write with ts=0 is silently dropped; thr is unchanged and there is no error flag.
- Shift register sh[7:0], bit counter cnt_bits[2:0], stop counter cnt_stop[0:0].
- FSM states: IDLE, START, DATA, STOP. All transitions below happen only on edges with en_tx=1; with en_tx=0 all registers except the thr write path hold.
  - IDLE: txd=1.
    - If thr_full: sh <= thr, thr_full <= 0, txd <= 0, next state START.
    - Otherwise: stay in IDLE.
  - START: txd <= sh[0], sh <= sh>>1, cnt_bits <= 7, next state DATA.
  - DATA:
    - If cnt_bits==0: txd <= 1, cnt_stop <= STOP_BITS-1, next state STOP.
    - Else: txd <= sh[0], sh <= sh>>1, cnt_bits <= cnt_bits-1.
  - STOP:
    - If cnt_stop!=0: cnt_stop <= cnt_stop-1, txd stays 1.
    - Else if thr_full: reload exactly as in IDLE and go to START (back-to-back frame).
    - Else: go to IDLE.
- Every line bit, stop bits included, is held for exactly one en_tx period.
- Simultaneous we and reload on the same edge: we is evaluated against ts before the edge. A write is therefore accepted only if thr was already empty, and reload and write never target thr on the same edge.
- busy = (state != IDLE), decoded from registered state.
- Illegal state encodings recover to IDLE with txd <= 1.

## Timing
- Reset values: txd=1, ts=1, busy=0, state=IDLE, thr=0, sh=0, thr_full=0, counters=0.
- Asserting rst mid-frame forces txd=1 immediately (asynchronous). The partial frame and any held byte are discarded.
- ts falls on the clk edge that accepts the write. It rises again on the en_tx edge that moves thr into sh.
- Latency from an accepted write in IDLE to the start bit on txd is the first en_tx edge strictly after the write edge.
  - If we and en_tx coincide in IDLE with ts=1: the byte is captured and the frame starts on the next en_tx edge, not on this one.
- Frame length is 10 en_tx periods (STOP_BITS=1) or 11 (STOP_BITS=2).
- The line is back-to-back if thr_full=1 at the final stop-bit en_tx edge; the next start bit directly follows the last stop bit.
- Continuous en_tx=1 is legal and gives one bit per clk.

## Test plan
- Reset, en_tx pulsed every 4 clk, write 0xA5 in IDLE -> txd per bit period = 0,1,0,1,0,0,1,0,1,1. ts low for the first en_tx period only; busy high for exactly 10 periods, then txd=1 and busy=0.
- Write 0x55, and on the clk after ts returns to 1 write 0x0F -> two contiguous frames: 0,1,0,1,0,1,0,1,0,1 then 0,1,1,1,1,0,0,0,0,1. No extra idle bit between them; busy stays high for 20 periods.
- Write 0x01, then 0x02 while ts=1, then 0x03 while ts=0 -> only 0x01 and 0x02 are transmitted; 0x03 is dropped and ts stays 0 until the second reload.
- STOP_BITS=2, write 0xFF -> 0 followed by ten 1s (eight data bits plus two stop bits); busy high for 11 periods.
- Assert rst during data bit 4 of 0x00 -> txd=1 within the same cycle, ts=1, busy=0. A write of 0x80 after release transmits cleanly: 0,0,0,0,0,0,0,0,1,1.
- en_tx held at 1, write 0x3C -> frame 0,0,0,1,1,1,1,0,0,1 at one bit per clk; we with ts=0 in mid-frame is ignored.
